// File: rtl/store_fsm.sv
// STORE sequencer: MEM[Ri] <- Rj, optional invalid-code trap under STORE_CODE_CHECK_EN.
// Latency: acceptance edge to done = 3+WRITE_CYCLES edges; outputs decoded from state (Moore).
// Backpressure: none; start is ignored until the FSM is back in IDLE.
module store_fsm #(
    parameter int WRITE_CYCLES = 2,
    parameter int CODE_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              donefetch,
    input  logic [CODE_W-1:0] parameter1,
    input  logic [CODE_W-1:0] parameter2,
    output logic              R0OutEn,
    output logic              R1OutEn,
    output logic              R2OutEn,
    output logic              R3OutEn,
    output logic              P0OutEn,
    output logic              MARin,
    output logic              MDR_frombusin,
    output logic              MDR_tomemOutEn,
    output logic              EN,
    output logic              RW,
    output logic              done,
    output logic              err
);

    generate
        if (WRITE_CYCLES < 1 || WRITE_CYCLES > 15) begin : g_bad_write_cycles
            $error("store_fsm: WRITE_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef STORE_CODE_CHECK_EN
    localparam logic [2:0] S_ERR   = 3'd5;
`endif

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              start_q;
    logic [CODE_W-1:0] a1;
    logic [CODE_W-1:0] d1;
    logic [3:0]        wcnt;
    logic              accept;
    logic [4:0]        oe;

    // Bit order of the one-hot select: [0]=R0 [1]=R1 [2]=R2 [3]=R3 [4]=P0.
    function automatic logic [4:0] code_sel(input logic [CODE_W-1:0] c);
        logic [4:0] s;
        s = 5'b00000;
        if (c == CODE_W'(0)) s = 5'b00001;
        if (c == CODE_W'(1)) s = 5'b00010;
        if (c == CODE_W'(2)) s = 5'b00100;
        if (c == CODE_W'(3)) s = 5'b01000;
        if (c == CODE_W'(4)) s = 5'b10000;
        return s;
    endfunction

    assign accept = (state == S_IDLE) && start && !start_q && donefetch;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
`ifdef STORE_CODE_CHECK_EN
                    if (code_sel(parameter1) == 5'b0 || code_sel(parameter2) == 5'b0)
                        state_nxt = S_ERR;
                    else
                        state_nxt = S_ADDR;
`else
                    state_nxt = S_ADDR;
`endif
                end
            end
            S_ADDR:  state_nxt = S_DATA;
            S_DATA:  state_nxt = S_WRITE;
            S_WRITE: if (wcnt == 4'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            start_q <= 1'b0;
            a1      <= '0;
            d1      <= '0;
            wcnt    <= 4'd0;
        end else begin
            state   <= state_nxt;
            start_q <= start;
            if (accept) begin
                a1 <= parameter1;
                d1 <= parameter2;
            end
            // Counter is loaded on the DATA->WRITE edge so it reads WRITE_CYCLES-1 on WRITE entry.
            if (state == S_DATA)
                wcnt <= 4'(WRITE_CYCLES - 1);
            else if (state == S_WRITE && wcnt != 4'd0)
                wcnt <= wcnt - 4'd1;
        end
    end

    always_comb begin
        oe             = 5'b00000;
        MARin          = 1'b0;
        MDR_frombusin  = 1'b0;
        MDR_tomemOutEn = 1'b0;
        EN             = 1'b0;
        RW             = 1'b1;
        done           = 1'b0;
`ifdef STORE_CODE_CHECK_EN
        err            = 1'b0;
`endif
        case (state)
            S_ADDR: begin
                oe    = code_sel(a1);
                MARin = 1'b1;
            end
            S_DATA: begin
                oe            = code_sel(d1);
                MDR_frombusin = 1'b1;
            end
            S_WRITE: begin
                MDR_tomemOutEn = 1'b1;
                EN             = 1'b1;
                RW             = 1'b0;
            end
            S_DONE: done = 1'b1;
`ifdef STORE_CODE_CHECK_EN
            S_ERR: begin
                err  = 1'b1;
                done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

`ifndef STORE_CODE_CHECK_EN
    assign err = 1'b0;
`endif

    assign R0OutEn = oe[0];
    assign R1OutEn = oe[1];
    assign R2OutEn = oe[2];
    assign R3OutEn = oe[3];
    assign P0OutEn = oe[4];

endmodule

// File: tb/tb_store_fsm.sv
// Bench for store_fsm: two instances (WRITE_CYCLES=2 and 4) share inputs and are
// compared every cycle against a step-index model of the store sequence.
module tb_store_fsm;

`ifdef STORE_CODE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, donefetch;
    logic [5:0] p1, p2;

    logic [11:0] obs [2];
    int          wcs [2] = '{2, 4};

    int checks = 0;
    int errors = 0;

    bit m_act [2];
    bit m_err [2];
    bit m_sq  [2];
    int m_k   [2];
    int m_a   [2];
    int m_d   [2];

    always #5 clk = ~clk;

    logic r0_0, r1_0, r2_0, r3_0, pp_0, mar_0, mfb_0, mtm_0, en_0, rw_0, dn_0, er_0;
    logic r0_1, r1_1, r2_1, r3_1, pp_1, mar_1, mfb_1, mtm_1, en_1, rw_1, dn_1, er_1;

    store_fsm u0 (
        .clk(clk), .rst(rst), .start(start), .donefetch(donefetch),
        .parameter1(p1), .parameter2(p2),
        .R0OutEn(r0_0), .R1OutEn(r1_0), .R2OutEn(r2_0), .R3OutEn(r3_0), .P0OutEn(pp_0),
        .MARin(mar_0), .MDR_frombusin(mfb_0), .MDR_tomemOutEn(mtm_0),
        .EN(en_0), .RW(rw_0), .done(dn_0), .err(er_0)
    );

    store_fsm #(.WRITE_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .start(start), .donefetch(donefetch),
        .parameter1(p1), .parameter2(p2),
        .R0OutEn(r0_1), .R1OutEn(r1_1), .R2OutEn(r2_1), .R3OutEn(r3_1), .P0OutEn(pp_1),
        .MARin(mar_1), .MDR_frombusin(mfb_1), .MDR_tomemOutEn(mtm_1),
        .EN(en_1), .RW(rw_1), .done(dn_1), .err(er_1)
    );

    assign obs[0] = {r0_0, r1_0, r2_0, r3_0, pp_0, mar_0, mfb_0, mtm_0, en_0, rw_0, dn_0, er_0};
    assign obs[1] = {r0_1, r1_1, r2_1, r3_1, pp_1, mar_1, mfb_1, mtm_1, en_1, rw_1, dn_1, er_1};

    // Step k of an accepted store: 0=address, 1=data, 2..wc+1=write, wc+2=done.
    function automatic logic [11:0] exp_vec(input int i);
        logic [4:0] oe;
        logic       wr;
        int         code;
        oe = 5'b0;
        code = -1;
        if (m_act[i] && m_k[i] == 0) code = m_a[i];
        if (m_act[i] && m_k[i] == 1) code = m_d[i];
        if (code >= 0 && code <= 4) oe[code] = 1'b1;
        wr = m_act[i] && m_k[i] >= 2 && m_k[i] <= wcs[i] + 1;
        return {oe[0], oe[1], oe[2], oe[3], oe[4],
                m_act[i] && m_k[i] == 0, m_act[i] && m_k[i] == 1, wr, wr, !wr,
                (m_act[i] && m_k[i] == wcs[i] + 2) || m_err[i], m_err[i]};
    endfunction

    task automatic model_step(input int i);
        bit busy;
        busy = m_act[i] || m_err[i];
        if (rst) begin
            m_act[i] = 1'b0;
            m_err[i] = 1'b0;
            m_sq[i]  = 1'b0;
        end else begin
            if (m_err[i]) m_err[i] = 1'b0;
            else if (m_act[i]) begin
                m_k[i]++;
                if (m_k[i] > wcs[i] + 2) m_act[i] = 1'b0;
            end
            if (!busy && start && !m_sq[i] && donefetch) begin
                m_a[i] = int'(p1);
                m_d[i] = int'(p2);
                if (CHK && (p1 > 6'd4 || p2 > 6'd4)) m_err[i] = 1'b1;
                else begin
                    m_act[i] = 1'b1;
                    m_k[i]   = 0;
                end
            end
            m_sq[i] = start;
        end
    endtask

    task automatic check_dut(input int i);
        logic [11:0] e;
        e = exp_vec(i);
        checks++;
        assert (obs[i] === e) else begin
            errors++;
            $error("FAIL outputs u%0d obs=%b exp=%b t=%0t", i, obs[i], e, $time);
        end
        checks++;
        assert (($countones(obs[i][11:7]) <= 1) === 1'b1) else begin
            errors++;
            $error("FAIL one_oe u%0d obs=%b exp=at most one t=%0t", i, obs[i][11:7], $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) cyc();
    endtask

    task automatic check_val(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
        end
    endtask

    initial begin
        int lat0, lat1, en0, en1, dn_seen;
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_err[i] = 0; m_sq[i] = 0; m_k[i] = 0; m_a[i] = 0; m_d[i] = 0;
        end
        rst = 1'b1; start = 1'b0; donefetch = 1'b0; p1 = '0; p2 = '0;
        run(2);
        rst = 1'b0;
        run(1);

        // Basic store R0 -> addr, R2 -> data, with latency and write-length measurement.
        donefetch = 1'b1; p1 = 6'd0; p2 = 6'd2; start = 1'b1;
        cyc();
        lat0 = 0; lat1 = 0; en0 = 0; en1 = 0;
        for (int e = 2; e <= 12; e++) begin
            cyc();
            if (dn_0 === 1'b1 && lat0 == 0) lat0 = e;
            if (dn_1 === 1'b1 && lat1 == 0) lat1 = e;
            if (en_0 === 1'b1) en0++;
            if (en_1 === 1'b1) en1++;
        end
        check_val("latency_wc2", lat0, 5);
        check_val("latency_wc4", lat1, 7);
        check_val("en_cycles_wc2", en0, 2);
        check_val("en_cycles_wc4", en1, 4);
        start = 1'b0;
        run(1);

        // Gating: no donefetch, then held start without a rising edge, then a real edge.
        donefetch = 1'b0; start = 1'b1;
        run(3);
        donefetch = 1'b1;
        run(3);
        start = 1'b0;
        run(1);
        start = 1'b1; p1 = 6'd4; p2 = 6'd3;
        run(10);
        start = 1'b0;
        run(1);

        // Code latching: parameter2 changes while in ADDR.
        p1 = 6'd2; p2 = 6'd1; start = 1'b1;
        cyc();
        p2 = 6'd3; p1 = 6'd0; start = 1'b0;
        run(9);

        // Same register for address and data; donefetch drops after acceptance.
        p1 = 6'd3; p2 = 6'd3; start = 1'b1;
        cyc();
        donefetch = 1'b0; start = 1'b0;
        run(9);
        donefetch = 1'b1;

        // Reset mid-WRITE: done must not pulse.
        p1 = 6'd1; p2 = 6'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        run(3);
        rst = 1'b1;
        dn_seen = 0;
        for (int j = 0; j < 2; j++) begin
            cyc();
            if (dn_0 === 1'b1 || dn_1 === 1'b1) dn_seen++;
        end
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            cyc();
            if (dn_0 === 1'b1 || dn_1 === 1'b1) dn_seen++;
        end
        check_val("no_done_after_rst", dn_seen, 0);
        p1 = 6'd2; p2 = 6'd4; start = 1'b1;
        run(10);
        start = 1'b0;
        run(1);

        // Invalid address code.
        p1 = 6'd7; p2 = 6'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        run(9);

        // Randomized traffic.
        for (int j = 0; j < 600; j++) begin
            start     = ($urandom_range(0, 2) != 0);
            donefetch = ($urandom_range(0, 3) != 0);
            p1        = 6'($urandom_range(0, 7));
            p2        = 6'($urandom_range(0, 7));
            rst       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0; start = 1'b0;
        run(12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_fsm.md
Name: store_fsm

Overview:
- Moore control FSM for the STORE instruction, the write-direction counterpart of the load sequencer: MEM[Ri] <- Rj.
- Driven by the instruction decoder after fetch completes.
- Sequences register out-enables, MAR/MDR latch strobes and memory EN/RW so Ri's value becomes the address and Rj's value is written to memory.
- Pulses done when finished.

Parameters:
- WRITE_CYCLES, 2, cycles memory write strobe (EN=1, RW=0) is held; legal range 1..15.
- CODE_W, 6, width of register-select codes parameter1/parameter2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  store request from decoder; accepted on rising edge only.
- donefetch  input  1  fetch complete; start accepted only while 1.
- parameter1  input  6  address register code (Ri).
- parameter2  input  6  data register code (Rj).
- R0OutEn, R1OutEn, R2OutEn, R3OutEn, P0OutEn  output  1 each  register-to-bus enables.
- MARin  output  1  MAR loads from bus.
- MDR_frombusin  output  1  MDR loads from bus.
- MDR_tomemOutEn  output  1  MDR drives memory data lines.
- EN  output  1  memory enable.
- RW  output  1  1=read, 0=write.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle invalid-code pulse (see Optional Feature).

Behaviour:
- Reset: clk/rst synchronous. rst=1 at an edge forces IDLE and clears start_q and latched codes. All outputs 0 except RW=1 (read is the safe idle level).
- Register codes: 000000=R0, 000001=R1, 000010=R2, 000011=R3, 000100=P0. All others invalid.
- Start detection: start_q registers start each cycle. Accept when state=IDLE, start=1, start_q=0, donefetch=1.
  - On acceptance, parameter1/parameter2 are latched into a1/d1. Later input changes are ignored until the next acceptance.
  - start held high across done does not retrigger.
- States, outputs decoded from state only:
  - IDLE: all strobes 0, RW=1. Goes to ADDR on acceptance.
  - ADDR (1 cycle): out-enable selected by a1=1, MARin=1. Goes to DATA.
  - DATA (1 cycle): out-enable selected by d1=1, MDR_frombusin=1. Goes to WRITE.
  - WRITE (WRITE_CYCLES cycles): MDR_tomemOutEn=1, EN=1, RW=0. A 4-bit counter loads WRITE_CYCLES-1 on entry and decrements; exit to DONE when the counter is 0.
  - DONE (1 cycle): done=1, all strobes 0, RW=1. Goes to IDLE.
- Latency: acceptance edge to done high is 3+WRITE_CYCLES edges (default 5). Next acceptance is possible the cycle after DONE.
- At most one register out-enable is high in any cycle, so the bus is never double-driven.
- a1==d1 is legal: the same register is driven in ADDR and DATA, and memory receives its own address.
- rst mid-sequence: next state IDLE, outputs as reset, no done. A memory write in progress is aborted.
- donefetch falling after acceptance has no effect.
- WRITE_CYCLES outside 1..15 is a configuration error, caught by an elaboration-time check.

Optional Feature:
- Macro: STORE_CODE_CHECK_EN.
- Defined: on acceptance, if a1 or d1 is invalid, go to ERR instead of ADDR.
  - ERR (1 cycle): err=1, done=1, no strobes, no memory access. Goes to IDLE.
- Undefined: no ERR state and err is tied 0. Invalid codes raise no out-enable in the corresponding state; the sequence and timing are otherwise unchanged.

Test Plan:
- Reset: rst=1 for 2 edges mid-WRITE -> next cycle all outputs 0, RW=1, done never pulses. A fresh start then completes normally.
- Basic store: donefetch=1, parameter1=000000, parameter2=000010, start rises -> ADDR: R0OutEn=1, MARin=1. DATA: R2OutEn=1, MDR_frombusin=1. WRITE: 2 cycles of EN=1, RW=0, MDR_tomemOutEn=1. done=1 exactly 5 edges after acceptance.
- Gating and edge detect: start=1 with donefetch=0 -> stays IDLE. Hold start=1, then set donefetch=1 -> no acceptance (no rising edge). Drop start and raise again -> accepted.
- Code latching: parameter2 changed from 000001 to 000011 during ADDR -> DATA still asserts R1OutEn only. Exactly one out-enable high in every cycle.
- WRITE_CYCLES=4 with P0 as address (000100) -> P0OutEn in ADDR, EN high for 4 consecutive cycles, done 7 edges after acceptance.
- STORE_CODE_CHECK_EN defined, parameter1=000111 -> one cycle with err=1 and done=1, EN never high. Macro undefined, same stimulus -> no out-enable in ADDR, full write sequence runs, err stays 0.
